// File: rtl/muldiv_pkg.sv
// Shared opcode and FSM state encodings for the iterative multiply/divide unit.
// Divider support is selected at build time with MULDIV_DIV_EN.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply, or restoring divide when
// MULDIV_DIV_EN is defined (otherwise divide mode holds the state).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic [WIDTH-1:0]   bits,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0]   bits_nx
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
`endif

  always_comb begin
    // Multiply: add multiplicand into the upper half, then shift product right.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bits[0] ? {1'b0, opnd} : '0);
    acc_nx  = {sum, acc[WIDTH-1:1]};
    bits_nx = {1'b0, bits[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // Divide: remainder lives in acc[WIDTH-1:0], dividend/quotient in bits.
    shifted = {acc[WIDTH-1:0], bits[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    if (div_mode) begin
      acc_nx  = {{WIDTH{1'b0}}, (ge ? diff : shifted[WIDTH-1:0])};
      bits_nx = {bits[WIDTH-2:0], ge};
    end
`else
    if (div_mode) begin
      acc_nx  = acc;
      bits_nx = bits;
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; one op at a time via start/busy.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO complete here in one cycle
// RUN     | WIDTH iterations of the multiply/divide step
// FIX     | sign correction, HI/LO write, done pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [2*WIDTH-1:0] acc, acc_nx, acc_step;
  logic [WIDTH-1:0]   bits, bits_nx, bits_step;
  logic [WIDTH-1:0]   opnd, opnd_nx;
  logic               neg_lo, neg_lo_nx;
  logic [WIDTH-1:0]   hi_nx, lo_nx;
  logic               done_nx;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic               step_div;
`ifdef MULDIV_DIV_EN
  logic               is_div, is_div_nx;
  logic               neg_hi, neg_hi_nx;
  logic [WIDTH-1:0]   quo, rem;
`endif

  assign sgn   = op_signed(op);
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign prod  = neg_lo ? -acc : acc;
  assign busy  = (state != ST_IDLE);

`ifdef MULDIV_DIV_EN
  assign step_div = is_div;
  assign quo      = neg_lo ? -bits : bits;
  assign rem      = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`else
  assign step_div = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .bits     (bits),
    .div_mode (step_div),
    .acc_nx   (acc_step),
    .bits_nx  (bits_step)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    bits_nx   = bits;
    opnd_nx   = opnd;
    neg_lo_nx = neg_lo;
    hi_nx     = hi;
    lo_nx     = lo;
    done_nx   = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_nx = is_div;
    neg_hi_nx = neg_hi;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_nx  = ST_RUN;
              cnt_nx    = '0;
              acc_nx    = '0;
              bits_nx   = b_mag;
              opnd_nx   = a_mag;
              neg_lo_nx = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
              is_div_nx = 1'b0;
              neg_hi_nx = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
              // Divide by zero keeps the all-ones quotient unsigned; remainder
              // then comes back as the original dividend.
              state_nx  = ST_RUN;
              cnt_nx    = '0;
              acc_nx    = '0;
              bits_nx   = a_mag;
              opnd_nx   = b_mag;
              neg_lo_nx = (a_neg ^ b_neg) & (b != '0);
              neg_hi_nx = a_neg;
              is_div_nx = 1'b1;
`else
              done_nx = 1'b1;
`endif
            end
            OP_MTHI: begin
              hi_nx   = a;
              done_nx = 1'b1;
            end
            OP_MTLO: begin
              lo_nx   = a;
              done_nx = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else begin
          acc_nx  = acc_step;
          bits_nx = bits_step;
          cnt_nx  = cnt + 1'b1;
          if (cnt == LAST) state_nx = ST_FIX;
        end
      end
      ST_FIX: begin
        state_nx = ST_IDLE;
        if (!abort) begin
          done_nx = 1'b1;
          hi_nx   = prod[2*WIDTH-1:WIDTH];
          lo_nx   = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            hi_nx = rem;
            lo_nx = quo;
          end
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      bits   <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      acc    <= acc_nx;
      bits   <= bits_nx;
      opnd   <= opnd_nx;
      neg_lo <= neg_lo_nx;
      hi     <= hi_nx;
      lo     <= lo_nx;
      done   <= done_nx;
`ifdef MULDIV_DIV_EN
      is_div <= is_div_nx;
      neg_hi <= neg_hi_nx;
`endif
    end
  end

endmodule
